// File: rtl/axis_tx_frame_arbiter.sv
// Round-robin, frame-granular arbiter that feeds N AXIS byte sources into the GMII TX sink.
// Frames longer than MAX_LEN beats are closed with tlast+tuser and their tail is discarded.
module axis_tx_frame_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned MAX_LEN = 1536,
  parameter int unsigned GW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_PORTS-1:0]   io_in_valid,
  output logic [N_PORTS-1:0]   io_in_ready,
  input  logic [8*N_PORTS-1:0] io_in_tdata,
  input  logic [N_PORTS-1:0]   io_in_tlast,
  input  logic [N_PORTS-1:0]   io_in_tuser,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [7:0]           io_out_tdata,
  output logic                 io_out_tlast,
  output logic                 io_out_tuser,
  output logic [GW-1:0]        io_grant,
  output logic                 io_busy,
  output logic                 io_trunc
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [LW-1:0] count_q, count_d;
  logic          trunc_q, trunc_d;

  logic          sel_valid, sel_last, sel_user, at_max;
  logic [7:0]    sel_data;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  int unsigned   cand;

  always_comb begin
    sel_valid = io_in_valid[grant_q];
    sel_last  = io_in_tlast[grant_q];
    sel_user  = io_in_tuser[grant_q];
    sel_data  = io_in_tdata[{grant_q, 3'b000} +: 8];
    at_max    = (count_q == LW'(MAX_LEN - 1));
  end

  // Search starts one past the previous winner and wraps without a modulo.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= N_PORTS; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      if (!pick_found && io_in_valid[GW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    count_d      = count_q;
    trunc_d      = 1'b0;
    io_out_valid = 1'b0;
    io_out_tdata = '0;
    io_out_tlast = 1'b0;
    io_out_tuser = 1'b0;
    io_in_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = PASS;
        end
      end
      PASS: begin
        io_out_valid         = sel_valid;
        io_out_tdata         = sel_data;
        io_out_tlast         = sel_last | at_max;
        io_out_tuser         = sel_user | (at_max & ~sel_last);
        io_in_ready[grant_q] = io_out_ready;
        if (sel_valid && io_out_ready) begin
          if (sel_last) begin
            last_d  = grant_q;
            count_d = '0;
            state_d = IDLE;
          end else if (at_max) begin
            count_d = '0;
            trunc_d = 1'b1;
            state_d = DROP;
          end else begin
            count_d = count_q + LW'(1);
          end
        end
      end
      DROP: begin
        io_in_ready[grant_q] = 1'b1;
        if (sel_valid && sel_last) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_PORTS - 1);
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

  assign io_grant = grant_q;
  assign io_busy  = (state_q != IDLE);
  assign io_trunc = trunc_q;

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Bench for axis_tx_frame_arbiter: queued sources, a frame-level round-robin model
// and per-beat comparison of the output stream.
module tb_axis_tx_frame_arbiter;

  localparam int unsigned N    = 3;
  localparam int unsigned MAXL = 32;
  localparam int unsigned GW   = 2;

  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  typedef struct packed {logic [7:0] d; logic l; logic u; logic [GW-1:0] g;} exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_vld, in_rdy, in_last, in_user;
  logic [8*N-1:0] in_data;
  logic           out_valid, out_ready, out_last, out_user, busy, trunc;
  logic [7:0]     out_data;
  logic [GW-1:0]  grant;

  beat_t src_q [N][$];
  beat_t mdl_q [N][$];
  exp_t  exp_q [$];
  int    mdl_last;
  int    exp_trunc;
  bit    mid_frame [N];
  int    n_cmp = 0;
  int    n_err = 0;

  axis_tx_frame_arbiter #(.N_PORTS(N), .MAX_LEN(MAXL)) dut (
    .clock(clk), .reset(rst),
    .io_in_valid(in_vld), .io_in_ready(in_rdy), .io_in_tdata(in_data),
    .io_in_tlast(in_last), .io_in_tuser(in_user),
    .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_tdata(out_data),
    .io_out_tlast(out_last), .io_out_tuser(out_user),
    .io_grant(grant), .io_busy(busy), .io_trunc(trunc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic load_frame(input int p, input int len, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = rnd ? 8'($urandom) : 8'(i);
      b.l = (i == len - 1);
      b.u = rnd ? ($urandom_range(7) == 0) : 1'b0;
      src_q[p].push_back(b);
      mdl_q[p].push_back(b);
    end
  endtask

  // Whole frames in round-robin order; beat MAXL of a longer frame becomes last+error.
  task automatic build_expected();
    int    p, n;
    bit    found;
    beat_t b;
    exp_t  e;
    exp_trunc = 0;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      p = 0;
      for (int i = 1; i <= N; i++) begin
        if (!found && mdl_q[(mdl_last + i) % N].size() > 0) begin
          found = 1'b1;
          p = (mdl_last + i) % N;
        end
      end
      if (found) begin
        n = 0;
        do begin
          b = mdl_q[p].pop_front();
          n++;
          if (n <= MAXL) begin
            e.d = b.d;
            e.g = GW'(p);
            if (n == MAXL && !b.l) begin
              e.l = 1'b1;
              e.u = 1'b1;
              exp_trunc++;
            end else begin
              e.l = b.l;
              e.u = b.u;
            end
            exp_q.push_back(e);
          end
        end while (!b.l);
        mdl_last = p;
      end
    end
  endtask

  function automatic bit srcs_empty();
    for (int p = 0; p < N; p++) if (src_q[p].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run(input int mode, input bit gaps, output int first_cyc);
    int           cyc, trunc_seen;
    logic [N-1:0] acc, mask, exp_rdy;
    beat_t        b;
    exp_t         e, got;
    cyc = 0;
    trunc_seen = 0;
    first_cyc = -1;
    acc = '0;
    while (1) begin
      @(negedge clk);
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin
          b = src_q[p].pop_front();
          mid_frame[p] = !b.l;
          in_vld[p] = 1'b0; in_data[8*p +: 8] = 8'h00; in_last[p] = 1'b0; in_user[p] = 1'b0;
        end
      end
      acc = '0;
      if (exp_q.size() == 0 && srcs_empty() && !busy) break;
      if (cyc >= 4000) begin
        n_cmp++; n_err++;
        $display("FAIL run_timeout: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
        break;
      end
      for (int p = 0; p < N; p++) begin
        if (!in_vld[p] && src_q[p].size() > 0 &&
            (!mid_frame[p] || !gaps || $urandom_range(3) != 0)) begin
          in_vld[p] = 1'b1;
          in_data[8*p +: 8] = src_q[p][0].d;
          in_last[p] = src_q[p][0].l;
          in_user[p] = src_q[p][0].u;
        end
      end
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
      #4;
      exp_rdy = '0;
      mask = '0;
      if (busy && out_valid) exp_rdy[grant] = out_ready;
      if (busy && !out_valid) mask = N'(1) << grant;
      n_cmp++;
      if (((in_rdy & ~mask) !== exp_rdy) || (out_valid && !busy)) begin
        n_err++;
        $display("FAIL ready_rule cyc=%0d: in_ready=%b out_valid=%b busy=%b, required in_ready=%b (mask %b)",
                 cyc, in_rdy, out_valid, busy, exp_rdy, mask);
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        got = {out_data, out_last, out_user, grant};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_beat extra: got d=%h l=%b u=%b g=%0d, required none", out_data, out_last, out_user, grant);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL out_beat: got d=%h l=%b u=%b g=%0d, required d=%h l=%b u=%b g=%0d",
                     got.d, got.l, got.u, got.g, e.d, e.l, e.u, e.g);
          end
        end
      end
      if (trunc) trunc_seen++;
      acc = in_vld & in_rdy;
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_beats: %0d undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (trunc_seen != exp_trunc) begin
      n_err++;
      $display("FAIL trunc_pulses: got %0d, required %0d", trunc_seen, exp_trunc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_vld = '1; in_data = '1; in_last = '1; in_user = '1; out_ready = 1'b1;
    #3;
    n_cmp++;
    if ({in_rdy, out_valid, out_data, out_last, out_user, grant, busy, trunc} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h l=%b u=%b g=%0d busy=%b trunc=%b, required all 0",
               in_rdy, out_valid, out_data, out_last, out_user, grant, busy, trunc);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_rdy, out_valid, grant, busy, trunc} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: got rdy=%b v=%b g=%0d busy=%b trunc=%b, required all 0",
               in_rdy, out_valid, grant, busy, trunc);
    end
    in_vld = '0; in_data = '0; in_last = '0; in_user = '0;
    rst = 1'b0;
    mdl_last = N - 1;
  endtask

  task automatic test_back_to_back();
    int fc;
    for (int k = 0; k < 2; k++) begin
      load_frame(0, 8, 1'b1);
      load_frame(1, 8, 1'b1);
    end
    build_expected();
    run(0, 1'b0, fc);
  endtask

  task automatic test_single_frame();
    int fc;
    load_frame(0, MAXL, 1'b0);
    build_expected();
    run(0, 1'b0, fc);
    n_cmp++;
    if (fc !== 1) begin
      n_err++;
      $display("FAIL first_beat_latency: got cycle %0d, required 1", fc);
    end
    n_cmp++;
    if (grant !== GW'(0) || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_grant_hold: got grant=%0d busy=%b, required grant=0 busy=0", grant, busy);
    end
  endtask

  task automatic test_truncation();
    int fc;
    load_frame(1, MAXL + 4, 1'b0);
    load_frame(1, 4, 1'b0);
    load_frame(0, 6, 1'b1);
    load_frame(2, MAXL + 1, 1'b1);
    build_expected();
    run(0, 1'b0, fc);
  endtask

  task automatic test_ready_toggle();
    int fc;
    load_frame(2, 10, 1'b1);
    build_expected();
    run(1, 1'b0, fc);
  endtask

  task automatic test_random();
    int fc;
    for (int k = 0; k < 14; k++) load_frame($urandom_range(N - 1), $urandom_range(1, MAXL + 8), 1'b1);
    build_expected();
    run(2, 1'b1, fc);
  endtask

  task automatic test_reset_midframe();
    int fc;
    load_frame(0, 4, 1'b1);
    build_expected();
    run(0, 1'b0, fc);
    out_ready = 1'b1;
    in_vld[1] = 1'b1;
    in_data[15:8] = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_data[15:8] = 8'(k);
    end
    n_cmp++;
    if (busy !== 1'b1 || grant !== GW'(1) || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midframe_state: got busy=%b grant=%0d v=%b, required busy=1 grant=1 v=1", busy, grant, out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_rdy, out_valid, out_data, out_last, out_user, grant, busy, trunc} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%b v=%b d=%h l=%b u=%b g=%0d busy=%b trunc=%b, required all 0",
               in_rdy, out_valid, out_data, out_last, out_user, grant, busy, trunc);
    end
    in_vld = '0; in_data = '0; in_last = '0; in_user = '0;
    @(negedge clk);
    rst = 1'b0;
    mdl_last = N - 1;
    for (int p = 0; p < N; p++) mid_frame[p] = 1'b0;
    load_frame(1, 5, 1'b1);
    load_frame(0, 5, 1'b1);
    build_expected();
    run(0, 1'b0, fc);
  endtask

  initial begin
    for (int p = 0; p < N; p++) mid_frame[p] = 1'b0;
    test_reset();
    test_back_to_back();
    test_single_frame();
    test_truncation();
    test_ready_toggle();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_tx_frame_arbiter.md
Name: axis_tx_frame_arbiter

Overview:
- Shares the single AXIS sink of the GMII transmitter (GmiiTx_AxisRx) between N_PORTS AXIS frame sources.
- Arbitrates round-robin, one whole frame at a time.
- Truncates runaway frames longer than MAX_LEN beats: the output frame is closed with tlast+tuser (error), and the rest of the input frame is discarded.
- Sits directly upstream of the GMII TX block in the MAC transmit path.

Parameters:
- N_PORTS, 2, number of requesting AXIS sources (2..8).
- MAX_LEN, 1536, maximum beats per frame before forced truncation (>=2).
- GW, 1, grant index width = max(1, clog2(N_PORTS)).
- LW, 11, beat counter width = clog2(MAX_LEN+1).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- io_in_valid  in  N_PORTS  per-port AXIS valid.
- io_in_ready  out  N_PORTS  per-port AXIS ready.
- io_in_tdata  in  8*N_PORTS  per-port data; port k at bits [8k+7:8k].
- io_in_tlast  in  N_PORTS  per-port end of frame.
- io_in_tuser  in  N_PORTS  per-port frame error.
- io_out_valid  out  1  to GMII TX io_axis_valid.
- io_out_ready  in  1  from GMII TX io_axis_ready.
- io_out_tdata  out  8  output data.
- io_out_tlast  out  1  output end of frame.
- io_out_tuser  out  1  output frame error.
- io_grant  out  GW  index of the port currently owning the output.
- io_busy  out  1  high while in PASS or DROP.
- io_trunc  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, beat count=0.
  - last-grant pointer=N_PORTS-1, so port 0 wins first.
  - io_grant=0; all outputs 0, including io_in_ready and io_out_valid.
- Reset mid-frame aborts immediately. No tlast is emitted; the downstream block is reset alongside.
- Beat accepted = valid & ready on the same clock edge.
- IDLE:
  - io_out_valid=0, all io_in_ready=0.
  - If any io_in_valid is high, pick the first valid port searching from last_grant+1 with wrap, register it as grant, go to PASS.
  - One bubble cycle per frame (grant registered); this is the arbitration latency.
- PASS (grant g):
  - io_out_valid/tdata/tlast/tuser = port g inputs (combinational).
  - io_in_ready[g]=io_out_ready; other ready bits = 0.
  - Count increments on each accepted beat.
  - Accepted beat with tlast: last_grant<=g, count<=0, go to IDLE.
  - Accepted beat number MAX_LEN (count==MAX_LEN-1) without tlast:
    - that beat is forced out with io_out_tlast=1, io_out_tuser=1.
    - io_trunc pulses the next cycle.
    - go to DROP.
  - tlast on exactly beat MAX_LEN is a normal end: no truncation, no tuser forcing.
  - tuser from the source passes through unchanged otherwise.
- DROP (grant g):
  - io_out_valid=0; io_in_ready[g]=1, others 0.
  - Beats are discarded until an accepted beat with tlast, then last_grant<=g and go to IDLE.
- Inputs are never reordered or duplicated. Non-granted ports stall with ready=0; sources hold valid/data stable (AXIS rules).
- Requests arriving during PASS are served only after the current frame ends. No preemption.
- io_grant holds its last value in IDLE. io_busy=1 in PASS and DROP.
- out_valid deassertion by the source mid-frame is passed through unchanged; the source is responsible for underrun.

Test Plan:
- Port 0 sends a 32-beat frame, data 0..31, out_ready=1 → out sees 32 beats 0..31, tlast only on beat 31; io_grant=0; one idle cycle before the first beat.
- Ports 0 and 1 both continuously send 8-beat frames → output order P0,P1,P0,P1; every frame contiguous; io_grant toggles per frame.
- MAX_LEN=16, port 1 sends 20 beats → output has 16 beats, beat 16 with tlast=1, tuser=1; io_trunc pulses once; the 4 remaining input beats are consumed with out_valid=0; next frame arbitrates normally.
- MAX_LEN=16, 16-beat frame with tlast on beat 16 → no tuser, no io_trunc.
- out_ready toggled 1/0 every cycle during a 10-beat frame → exactly 10 accepted beats, in order; in_ready mirrors out_ready.
- reset asserted at beat 5 of a frame → all outputs 0 asynchronously; after release, port 0 is granted first.
